// File: rtl/tile_collision_detector.sv
// Accumulates ball-vs-tile pixel overlaps per frame and runs the gift-consume handshake; optional pixel counter under COLLISION_PIXEL_COUNT_EN.
// Latency: hit flags and frameCollisionValid appear one cycle after the startOfFrame edge; giftConsumeReq rises in that same cycle.
// Backpressure: none on the pixel stream; while a consume is pending, further gift frames are reported but their requests are dropped.
module tile_collision_detector #(
    parameter int TILE_COL_W  = 4,
    parameter int TILE_ROW_W  = 3,
    parameter int ACK_TIMEOUT = 255
`ifdef COLLISION_PIXEL_COUNT_EN
    ,
    parameter int COUNT_W     = 12
`endif
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  ballDrawingRequest,
    input  logic                  tileDrawingRequest,
    input  logic [1:0]            tileDrawingType,
    input  logic [TILE_COL_W-1:0] tileCol,
    input  logic [TILE_ROW_W-1:0] tileRow,
    output logic                  frameCollisionValid,
    output logic                  hitFloor,
    output logic                  hitGift,
    output logic                  hitHole,
    output logic                  giftConsumeReq,
    output logic [TILE_COL_W-1:0] giftCol,
    output logic [TILE_ROW_W-1:0] giftRow,
    input  logic                  giftConsumeAck,
    output logic                  consumeTimeout,
    output logic                  giftDropped
`ifdef COLLISION_PIXEL_COUNT_EN
    ,
    output logic [COUNT_W-1:0]    overlapCount
`endif
);

    typedef enum logic {ST_ACCUM, ST_CONSUME} state_t;

    localparam logic [11:0] ACK_LAST = 12'(ACK_TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic                    floor_acc, gift_acc, hole_acc;
    logic [TILE_COL_W-1:0]   pend_col;
    logic [TILE_ROW_W-1:0]   pend_row;
    logic [11:0]             wait_cnt;
    logic                    start_consume, drop, timeout_hit;

    logic overlap, floor_ov, gift_ov, hole_ov;
    assign overlap  = ballDrawingRequest & tileDrawingRequest;
    assign floor_ov = overlap & ~tileDrawingType[1];
    assign gift_ov  = overlap & (tileDrawingType == 2'b10);
    assign hole_ov  = overlap & (tileDrawingType == 2'b11);

    assign giftConsumeReq = (state == ST_CONSUME);

    always_comb begin
        state_nxt     = state;
        start_consume = 1'b0;
        drop          = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            ST_ACCUM: begin
                if (startOfFrame && gift_acc) begin
                    state_nxt     = ST_CONSUME;
                    start_consume = 1'b1;
                end
            end
            ST_CONSUME: begin
                // ack takes priority over a timeout expiring in the same cycle
                if (giftConsumeAck) begin
                    state_nxt = ST_ACCUM;
                end else if (wait_cnt == ACK_LAST) begin
                    state_nxt   = ST_ACCUM;
                    timeout_hit = 1'b1;
                end
                if (startOfFrame && gift_acc)
                    drop = 1'b1;
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state               <= ST_ACCUM;
            floor_acc           <= 1'b0;
            gift_acc            <= 1'b0;
            hole_acc            <= 1'b0;
            hitFloor            <= 1'b0;
            hitGift             <= 1'b0;
            hitHole             <= 1'b0;
            pend_col            <= '0;
            pend_row            <= '0;
            giftCol             <= '0;
            giftRow             <= '0;
            wait_cnt            <= '0;
            frameCollisionValid <= 1'b0;
            consumeTimeout      <= 1'b0;
            giftDropped         <= 1'b0;
        end else begin
            state               <= state_nxt;
            frameCollisionValid <= startOfFrame;
            consumeTimeout      <= timeout_hit;
            giftDropped         <= drop;

            // overlap seen on the SOF cycle already belongs to the new frame
            if (startOfFrame) begin
                hitFloor  <= floor_acc;
                hitGift   <= gift_acc;
                hitHole   <= hole_acc;
                floor_acc <= floor_ov;
                gift_acc  <= gift_ov;
                hole_acc  <= hole_ov;
            end else begin
                floor_acc <= floor_acc | floor_ov;
                gift_acc  <= gift_acc | gift_ov;
                hole_acc  <= hole_acc | hole_ov;
            end

            if (gift_ov && (startOfFrame || !gift_acc)) begin
                pend_col <= tileCol;
                pend_row <= tileRow;
            end

            if (start_consume) begin
                giftCol  <= pend_col;
                giftRow  <= pend_row;
                wait_cnt <= '0;
            end else if (state == ST_CONSUME) begin
                wait_cnt <= wait_cnt + 12'd1;
            end
        end
    end

`ifdef COLLISION_PIXEL_COUNT_EN
    logic [COUNT_W-1:0] pix_cnt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pix_cnt      <= '0;
            overlapCount <= '0;
        end else if (startOfFrame) begin
            overlapCount <= pix_cnt;
            pix_cnt      <= overlap ? COUNT_W'(1) : '0;
        end else if (overlap && !(&pix_cnt)) begin
            pix_cnt <= pix_cnt + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tile_collision_detector.sv
// Directed bench for tile_collision_detector: reset, frame reporting, gift handshake (ack, timeout, drop) and SOF-coincident overlap.
module tb_tile_collision_detector;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       ballDrawingRequest;
    logic       tileDrawingRequest;
    logic [1:0] tileDrawingType;
    logic [3:0] tileCol;
    logic [2:0] tileRow;
    logic       frameCollisionValid;
    logic       hitFloor, hitGift, hitHole;
    logic       giftConsumeReq;
    logic [3:0] giftCol;
    logic [2:0] giftRow;
    logic       giftConsumeAck;
    logic       consumeTimeout;
    logic       giftDropped;
`ifdef COLLISION_PIXEL_COUNT_EN
    logic [11:0] overlapCount;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    tile_collision_detector #(
        .TILE_COL_W (4),
        .TILE_ROW_W (3),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .ballDrawingRequest (ballDrawingRequest),
        .tileDrawingRequest (tileDrawingRequest),
        .tileDrawingType    (tileDrawingType),
        .tileCol            (tileCol),
        .tileRow            (tileRow),
        .frameCollisionValid(frameCollisionValid),
        .hitFloor           (hitFloor),
        .hitGift            (hitGift),
        .hitHole            (hitHole),
        .giftConsumeReq     (giftConsumeReq),
        .giftCol            (giftCol),
        .giftRow            (giftRow),
        .giftConsumeAck     (giftConsumeAck),
        .consumeTimeout     (consumeTimeout),
        .giftDropped        (giftDropped)
`ifdef COLLISION_PIXEL_COUNT_EN
        ,
        .overlapCount       (overlapCount)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic b, input logic t, input logic [1:0] ty,
                          input logic [3:0] c, input logic [2:0] r);
        ballDrawingRequest = b;
        tileDrawingRequest = t;
        tileDrawingType    = ty;
        tileCol            = c;
        tileRow            = r;
    endtask

    task automatic test_reset;
        logic seen;
        resetN = 1'b0;
        startOfFrame = 1'b1;
        set_px(1'b1, 1'b1, 2'b10, 4'd5, 3'd5);
        tick;
        tick;
        chk_cnt++; if (frameCollisionValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", frameCollisionValid); else pass_cnt++;
        chk_cnt++; if ({hitFloor, hitGift, hitHole} !== 3'b000) $display("FAIL reset_hits: got %b want 000", {hitFloor, hitGift, hitHole}); else pass_cnt++;
        chk_cnt++; if (giftConsumeReq !== 1'b0) $display("FAIL reset_req: got %b want 0", giftConsumeReq); else pass_cnt++;
        chk_cnt++; if ({giftCol, giftRow} !== 7'd0) $display("FAIL reset_coords: got %0d/%0d want 0/0", giftCol, giftRow); else pass_cnt++;
        chk_cnt++; if ({consumeTimeout, giftDropped} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {consumeTimeout, giftDropped}); else pass_cnt++;
`ifdef COLLISION_PIXEL_COUNT_EN
        chk_cnt++; if (overlapCount !== 12'd0) $display("FAIL reset_count: got %0d want 0", overlapCount); else pass_cnt++;
`endif
        resetN = 1'b1;
        startOfFrame = 1'b0;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen = seen | frameCollisionValid;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL idle_no_valid: got %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_floor;
        set_px(1'b1, 1'b1, 2'b01, 4'd2, 3'd1);
        repeat (5) tick;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        tick;
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        chk_cnt++; if (frameCollisionValid !== 1'b1) $display("FAIL floor_valid: got %b want 1", frameCollisionValid); else pass_cnt++;
        chk_cnt++; if ({hitFloor, hitGift, hitHole} !== 3'b100) $display("FAIL floor_hits: got %b want 100", {hitFloor, hitGift, hitHole}); else pass_cnt++;
        chk_cnt++; if (giftConsumeReq !== 1'b0) $display("FAIL floor_no_req: got %b want 0", giftConsumeReq); else pass_cnt++;
`ifdef COLLISION_PIXEL_COUNT_EN
        chk_cnt++; if (overlapCount !== 12'd5) $display("FAIL floor_count: got %0d want 5", overlapCount); else pass_cnt++;
`endif
        tick;
        chk_cnt++; if (frameCollisionValid !== 1'b0) $display("FAIL floor_valid_pulse: got %b want 0", frameCollisionValid); else pass_cnt++;
        chk_cnt++; if (hitFloor !== 1'b1) $display("FAIL floor_hold: got %b want 1", hitFloor); else pass_cnt++;
    endtask

    task automatic test_gift_ack;
        set_px(1'b1, 1'b1, 2'b10, 4'd3, 3'd2);
        tick;
        set_px(1'b1, 1'b1, 2'b10, 4'd4, 3'd2);
        tick;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        chk_cnt++; if ({frameCollisionValid, giftConsumeReq} !== 2'b11) $display("FAIL gift_valid_req: got %b want 11", {frameCollisionValid, giftConsumeReq}); else pass_cnt++;
        chk_cnt++; if ({hitFloor, hitGift, hitHole} !== 3'b010) $display("FAIL gift_hits: got %b want 010", {hitFloor, hitGift, hitHole}); else pass_cnt++;
        chk_cnt++; if (giftCol !== 4'd3 || giftRow !== 3'd2) $display("FAIL gift_coords: got %0d/%0d want 3/2", giftCol, giftRow); else pass_cnt++;
        repeat (3) tick;
        chk_cnt++; if (giftConsumeReq !== 1'b1) $display("FAIL gift_req_held: got %b want 1", giftConsumeReq); else pass_cnt++;
        giftConsumeAck = 1'b1;
        tick;
        giftConsumeAck = 1'b0;
        chk_cnt++; if (giftConsumeReq !== 1'b0) $display("FAIL gift_req_drop: got %b want 0", giftConsumeReq); else pass_cnt++;
        chk_cnt++; if (consumeTimeout !== 1'b0) $display("FAIL gift_no_timeout: got %b want 0", consumeTimeout); else pass_cnt++;
        // ack while idle must not restart a request
        giftConsumeAck = 1'b1;
        tick;
        giftConsumeAck = 1'b0;
        tick;
        chk_cnt++; if ({giftConsumeReq, consumeTimeout} !== 2'b00) $display("FAIL idle_ack_ignored: got %b want 00", {giftConsumeReq, consumeTimeout}); else pass_cnt++;
    endtask

    task automatic test_timeout;
        int n;
        set_px(1'b1, 1'b1, 2'b10, 4'd3, 3'd2);
        tick;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        n = 0;
        while (giftConsumeReq === 1'b1 && n < 400) begin
            n++;
            tick;
        end
        chk_cnt++; if (n !== 255) $display("FAIL timeout_cycles: got %0d want 255", n); else pass_cnt++;
        chk_cnt++; if (consumeTimeout !== 1'b1) $display("FAIL timeout_pulse: got %b want 1", consumeTimeout); else pass_cnt++;
        tick;
        chk_cnt++; if (consumeTimeout !== 1'b0) $display("FAIL timeout_pulse_len: got %b want 0", consumeTimeout); else pass_cnt++;
    endtask

    task automatic test_drop;
        set_px(1'b1, 1'b1, 2'b10, 4'd3, 3'd2);
        tick;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        chk_cnt++; if (giftConsumeReq !== 1'b1) $display("FAIL drop_first_req: got %b want 1", giftConsumeReq); else pass_cnt++;
        set_px(1'b1, 1'b1, 2'b10, 4'd7, 3'd1);
        tick;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        chk_cnt++; if ({frameCollisionValid, hitGift} !== 2'b11) $display("FAIL drop_report: got %b want 11", {frameCollisionValid, hitGift}); else pass_cnt++;
        chk_cnt++; if (giftDropped !== 1'b1) $display("FAIL drop_pulse: got %b want 1", giftDropped); else pass_cnt++;
        chk_cnt++; if (giftCol !== 4'd3 || giftRow !== 3'd2 || giftConsumeReq !== 1'b1) $display("FAIL drop_coords: got %0d/%0d req %b want 3/2 req 1", giftCol, giftRow, giftConsumeReq); else pass_cnt++;
        tick;
        chk_cnt++; if (giftDropped !== 1'b0) $display("FAIL drop_pulse_len: got %b want 0", giftDropped); else pass_cnt++;
        giftConsumeAck = 1'b1;
        tick;
        giftConsumeAck = 1'b0;
        chk_cnt++; if (giftConsumeReq !== 1'b0) $display("FAIL drop_ack: got %b want 0", giftConsumeReq); else pass_cnt++;
    endtask

    task automatic test_sof_coincident;
        set_px(1'b1, 1'b1, 2'b11, 4'd1, 3'd1);
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        chk_cnt++; if (frameCollisionValid !== 1'b1) $display("FAIL coin_valid: got %b want 1", frameCollisionValid); else pass_cnt++;
        chk_cnt++; if ({hitFloor, hitGift, hitHole} !== 3'b000) $display("FAIL coin_hits_first: got %b want 000", {hitFloor, hitGift, hitHole}); else pass_cnt++;
        repeat (3) tick;
        startOfFrame = 1'b1;
        tick;
        startOfFrame = 1'b0;
        chk_cnt++; if ({hitFloor, hitGift, hitHole} !== 3'b001) $display("FAIL coin_hits_next: got %b want 001", {hitFloor, hitGift, hitHole}); else pass_cnt++;
        chk_cnt++; if (giftConsumeReq !== 1'b0) $display("FAIL coin_no_req: got %b want 0", giftConsumeReq); else pass_cnt++;
`ifdef COLLISION_PIXEL_COUNT_EN
        chk_cnt++; if (overlapCount !== 12'd1) $display("FAIL coin_count: got %0d want 1", overlapCount); else pass_cnt++;
`endif
    endtask

    initial begin
        resetN         = 1'b0;
        startOfFrame   = 1'b0;
        giftConsumeAck = 1'b0;
        set_px(1'b0, 1'b0, 2'b00, 4'd0, 3'd0);
        test_reset;
        test_floor;
        test_gift_ack;
        test_timeout;
        test_drop;
        test_sof_coincident;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
